// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared constants for the APB slave register file
package apb_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [31:0] ID_VALUE = 32'hA9B0_0001;

    localparam logic [3:0] REG_STATUS = 4'hE;
    localparam logic [3:0] REG_ID     = 4'hF;

    localparam int STATUS_PERR    = 0;
    localparam int STATUS_CNT_LSB = 1;
    localparam int STATUS_CNT_MSB = 4;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/apb_regbank.sv
// rtl/apb_regbank.sv - 14 r/w words, W1C STATUS with error counter, read-only ID
module apb_regbank
    import apb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  rd_idx_i,
    input  logic        perr_set_i,
    input  logic        err_inc_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] regs_q [0:13];
    logic        perr_q, perr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_status;
    logic [31:0] status_word;

    assign wr_status = wr_en_i && (wr_idx_i == REG_STATUS);

    // Clears are applied first so that a same-cycle set or increment wins.
    always_comb begin
        perr_d = perr_q;
        cnt_d  = cnt_q;
        if (wr_status && wr_data_i[STATUS_PERR]) begin
            perr_d = 1'b0;
        end
        if (wr_status && wr_data_i[STATUS_CNT_LSB]) begin
            cnt_d = 4'd0;
        end
        if (perr_set_i) begin
            perr_d = 1'b1;
        end
        if (err_inc_i) begin
            cnt_d = sat_inc4(cnt_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 14; i++) begin
                regs_q[i] <= '0;
            end
            perr_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            if (wr_en_i && (wr_idx_i < REG_STATUS)) begin
                regs_q[wr_idx_i] <= wr_data_i;
            end
            perr_q <= perr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_PERR] = perr_q;
        status_word[STATUS_CNT_MSB:STATUS_CNT_LSB] = cnt_q;
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_idx_i == REG_ID) begin
            rd_data_o = ID_VALUE;
        end else if (rd_idx_i == REG_STATUS) begin
            rd_data_o = status_word;
        end else begin
            rd_data_o = regs_q[rd_idx_i];
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB slave: setup/access FSM, wait states, error decode
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam logic [3:0]  WAIT_CNT = WAIT_STATES[3:0];
    localparam logic [25:0] BASE_TAG = BASE_ADDR[31:6];

    logic [0:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;

    logic        in_access;
    logic        xfer;
    logic        ready;
    logic        mismatch;
    logic        slverr;
    logic        perr_set;
    logic        wr_en;
    logic [31:0] rd_data;

    assign in_access = (state_q == ST_ACCESS);
    assign xfer      = Psel && Penable;
    assign ready     = in_access && xfer && (wcnt_q == WAIT_CNT);
    assign mismatch  = (Paddr != addr_q) || (Pwrite != write_q) || (Pwdata != wdata_q);

    // Error decode is on the latched setup values, not the live bus.
    assign slverr = (addr_q[1:0] != 2'b00)
                 || (addr_q[31:6] != BASE_TAG)
                 || (write_q && (addr_q[5:2] == REG_ID));

    // Missing setup, abort, or bus values changing under an active transfer.
    assign perr_set = (!in_access && xfer)
                   || (in_access && !xfer)
                   || (in_access && xfer && mismatch);

    assign wr_en   = ready && write_q && !slverr;
    assign Pready  = ready;
    assign Pslverr = ready && slverr;
    assign Prdata  = (ready && !write_q && !slverr) ? rd_data : 32'd0;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (Psel && !Penable) begin
                    state_d = ST_ACCESS;
                    wcnt_d  = 4'd0;
                    addr_d  = Paddr;
                    write_d = Pwrite;
                    wdata_d = Pwdata;
                end
            end
            default: begin
                if (!xfer || ready) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    apb_regbank u_regbank (
        .clk_i      (Hclk),
        .rst_ni     (Hresetn),
        .wr_en_i    (wr_en),
        .wr_idx_i   (addr_q[5:2]),
        .wr_data_i  (wdata_q),
        .rd_idx_i   (addr_q[5:2]),
        .perr_set_i (perr_set),
        .err_inc_i  (ready && slverr),
        .rd_data_o  (rd_data)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - scoreboard bench for two apb_slave_regfile instances (0 and 3 wait states)
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] ID   = 32'hA9B0_0001;
    localparam int          WS0  = 0;
    localparam int          WS1  = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [1:0]  psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int tests = 0;
    int fails = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] mem [2][16];
    logic        mperr [2];
    int          mcnt [2];

    always #5 Hclk = ~Hclk;

    apb_slave_regfile #(.BASE_ADDR(BASE), .WAIT_STATES(WS0)) dut0 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Psel(psel[0]), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0])
    );

    apb_slave_regfile #(.BASE_ADDR(BASE), .WAIT_STATES(WS1)) dut1 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Psel(psel[1]), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ws(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic logic [1:0] sel(input int d);
        return (d == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mem[d][i] = '0;
            mperr[d] = 1'b0;
            mcnt[d]  = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input int d, input int idx);
        if (idx == 15) return ID;
        if (idx == 14) return 32'(mcnt[d] * 2) | {31'd0, mperr[d]};
        return mem[d][idx];
    endfunction

    function automatic exp_t model_xfer(input int d, input logic [31:0] a, input logic wr,
                                        input logic [31:0] wd, input logic corrupt);
        exp_t e;
        int   idx;
        bit   err;
        idx = int'((a >> 2) & 32'hF);
        err = ((a % 4) != 0) || ((a >> 6) != (BASE >> 6)) || (wr && idx == 15);
        e.slverr = err;
        e.rdata  = '0;
        if (err) begin
            if (mcnt[d] < 15) mcnt[d] = mcnt[d] + 1;
        end else if (wr) begin
            if (idx == 14) begin
                if (wd[0]) mperr[d] = 1'b0;
                if (wd[1]) mcnt[d] = 0;
            end else begin
                mem[d][idx] = wd;
            end
        end else begin
            e.rdata = model_read(d, idx);
        end
        if (corrupt) mperr[d] = 1'b1;
        return e;
    endfunction

    task automatic xfer(input int d, input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, input logic corrupt);
        exp_t e;
        int   n;
        e = model_xfer(d, a, wr, wd, corrupt);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge Hclk); #1;
        psel = sel(d); Penable = 1'b0; Paddr = a; Pwrite = wr; Pwdata = wd;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        if (corrupt) Pwdata = wd ^ 32'h1;
        #1;
        n = 2;
        while (!pready[d] && n < 40) begin
            @(posedge Hclk); #2;
            n++;
        end
        check("latency", n, 2 + ws(d));
    endtask

    task automatic bus_idle();
        @(posedge Hclk); #1;
        psel = 2'b00; Penable = 1'b0;
    endtask

    task automatic abort_xfer(input int d, input logic [31:0] a, input logic wr, input logic [31:0] wd);
        int k;
        mperr[d] = 1'b1;
        k = (ws(d) == 0) ? 0 : $urandom_range(0, ws(d) - 1);
        @(posedge Hclk); #1;
        psel = sel(d); Penable = 1'b0; Paddr = a; Pwrite = wr; Pwdata = wd;
        for (int i = 0; i < k; i++) begin
            @(posedge Hclk); #1;
            Penable = 1'b1;
            #1 check("abort_wait_ready", 32'(pready[d]), 0);
        end
        @(posedge Hclk); #1;
        psel = 2'b00;
        #1 check("abort_ready", 32'(pready[d]), 0);
    endtask

    task automatic proto_err(input int d);
        mperr[d] = 1'b1;
        @(posedge Hclk); #1;
        psel = sel(d); Penable = 1'b1; Paddr = BASE; Pwrite = 1'b0;
        #1 check("proto_ready", 32'(pready[d]), 0);
        @(posedge Hclk); #1;
        psel = 2'b00; Penable = 1'b0;
    endtask

    task automatic reset_mid(input int d, input logic [31:0] a, input logic wr, input logic [31:0] wd);
        logic [31:0] exp_rd;
        exp_rd = (ws(d) == 0 && !wr) ? model_read(d, int'((a >> 2) & 32'hF)) : 32'd0;
        @(posedge Hclk); #1;
        psel = sel(d); Penable = 1'b0; Paddr = a; Pwrite = wr; Pwdata = wd;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        #1;
        check("pre_reset_ready", 32'(pready[d]), (ws(d) == 0) ? 32'd1 : 32'd0);
        check("pre_reset_rdata", prdata[d], exp_rd);
        Hresetn = 1'b0;
        #1;
        check("reset_ready", 32'(pready[d]), 0);
        check("reset_slverr", 32'(pslverr[d]), 0);
        check("reset_rdata", prdata[d], 0);
        psel = 2'b00; Penable = 1'b0;
        model_reset();
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int          c;
        logic [31:0] a;
        c = $urandom_range(0, 9);
        a = BASE + 32'($urandom_range(0, 15)) * 32'd4;
        if (c == 0) begin
            a = a + 32'($urandom_range(1, 3));
        end else if (c == 1) begin
            a = $urandom;
            if ((a >> 6) == (BASE >> 6)) a = a ^ 32'h4000_0000;
        end
        return a;
    endfunction

    always @(negedge Hclk) begin : monitor
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (pready[d]) begin
                if (d == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    check("rdata0", prdata[0], e.rdata);
                    check("slverr0", 32'(pslverr[0]), 32'(e.slverr));
                end else if (d == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    check("rdata1", prdata[1], e.rdata);
                    check("slverr1", 32'(pslverr[1]), 32'(e.slverr));
                end else begin
                    check("unexpected_ready", 32'(pready[d]), 0);
                end
            end else begin
                check("idle_rdata", prdata[d], 0);
                check("idle_slverr", 32'(pslverr[d]), 0);
            end
        end
    end

    initial begin
        int d;
        int op;
        Hresetn = 1'b0; psel = 2'b00; Penable = 1'b0; Pwrite = 1'b0;
        Paddr = '0; Pwdata = '0;
        model_reset();
        repeat (3) @(posedge Hclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(pready[i]), 0);
            check("rst_slverr", 32'(pslverr[i]), 0);
            check("rst_rdata", prdata[i], 0);
        end
        Hresetn = 1'b1;

        xfer(0, 32'h8000_0008, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xfer(0, 32'h8000_0008, 1'b0, 32'h0, 1'b0);

        xfer(1, 32'h8000_003C, 1'b0, 32'h0, 1'b0);

        xfer(1, 32'h8000_003C, 1'b1, 32'h1111_2222, 1'b0);
        xfer(1, 32'h8000_0042, 1'b1, 32'h3333_4444, 1'b0);
        xfer(1, 32'h9000_0000, 1'b1, 32'h5555_6666, 1'b0);
        xfer(1, 32'h8000_003C, 1'b0, 32'h0, 1'b0);
        xfer(1, 32'h8000_0038, 1'b0, 32'h0, 1'b0);
        xfer(1, 32'h8000_0038, 1'b1, 32'h2, 1'b0);
        xfer(1, 32'h8000_0038, 1'b0, 32'h0, 1'b0);

        abort_xfer(1, 32'h8000_0004, 1'b1, 32'h1234);
        xfer(1, 32'h8000_0004, 1'b0, 32'h0, 1'b0);
        xfer(1, 32'h8000_0038, 1'b0, 32'h0, 1'b0);
        xfer(1, 32'h8000_0038, 1'b1, 32'h1, 1'b0);
        xfer(1, 32'h8000_0038, 1'b0, 32'h0, 1'b0);

        proto_err(0);
        xfer(0, 32'h8000_0038, 1'b0, 32'h0, 1'b0);
        xfer(0, 32'h8000_0038, 1'b1, 32'h1, 1'b1);
        xfer(0, 32'h8000_0038, 1'b0, 32'h0, 1'b0);

        xfer(1, 32'h8000_0010, 1'b1, 32'hCAFE_F00D, 1'b0);
        reset_mid(1, 32'h8000_0014, 1'b1, 32'h0000_0055);
        xfer(0, 32'h8000_0008, 1'b1, 32'hDEAD_BEEF, 1'b0);
        reset_mid(0, 32'h8000_0008, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            xfer(0, BASE + 32'(i * 4), 1'b0, 32'h0, 1'b0);
            xfer(1, BASE + 32'(i * 4), 1'b0, 32'h0, 1'b0);
        end

        repeat (300) begin
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 19);
            if (op == 0) begin
                proto_err(d);
            end else if (op == 1) begin
                abort_xfer(d, BASE + 32'($urandom_range(0, 13)) * 32'd4,
                           1'($urandom_range(0, 1)), $urandom);
            end else begin
                xfer(d, rand_addr(), 1'($urandom_range(0, 1)), $urandom, op == 2);
            end
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        for (int i = 0; i < 16; i++) begin
            xfer(0, BASE + 32'(i * 4), 1'b0, 32'h0, 1'b0);
            xfer(1, BASE + 32'(i * 4), 1'b0, 32'h0, 1'b0);
        end
        bus_idle();
        repeat (4) @(posedge Hclk);
        #1;
        check("sb_drain0", 32'(q0.size()), 0);
        check("sb_drain1", 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low (Hclk, Hresetn).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, giving the slave window base (Paddr[31:6] compare).
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, range 0..15, giving the number of access-phase cycles with Pready low.
REQ-004 The block SHALL have port Hclk, input, 1, system clock.
REQ-005 The block SHALL have port Hresetn, input, 1, async active-low reset.
REQ-006 The block SHALL have port Psel, input, 1, select (one bit of the bridge's Pselx).
REQ-007 The block SHALL have port Penable, input, 1, access-phase strobe.
REQ-008 The block SHALL have port Pwrite, input, 1, 1 = write, 0 = read.
REQ-009 The block SHALL have port Paddr, input, 32, byte address.
REQ-010 The block SHALL have port Pwdata, input, 32, write data.
REQ-011 The block SHALL have port Prdata, output, 32, read data.
REQ-012 The block SHALL have port Pready, output, 1, transfer completion.
REQ-013 The block SHALL have port Pslverr, output, 1, transfer error, valid only with Pready.

Function
REQ-014 The register map SHALL be 16 x 32-bit words at Paddr[5:2]: 0x0-0xD read/write, 0xE STATUS, 0xF ID (read-only, 32'hA9B0_0001).
REQ-015 The FSM SHALL have states IDLE and ACCESS, plus a 4-bit wait counter wcnt.
REQ-016 In IDLE with Psel=1 and Penable=0, the block SHALL latch Paddr, Pwrite and Pwdata and go to ACCESS next cycle with wcnt=0.
REQ-017 In IDLE with Psel=1 and Penable=1 (no setup phase), the block SHALL set STATUS[0] (protocol error), stay in IDLE, and not assert Pready.
REQ-018 In ACCESS with Psel=1 and Penable=1, the block SHALL increment wcnt each cycle while wcnt < WAIT_STATES.
REQ-019 Pready SHALL be combinational: 1 only in ACCESS with Psel&Penable and wcnt==WAIT_STATES. Zero-wait transfers therefore take 2 cycles; in general 2+WAIT_STATES.
REQ-020 On the Pready cycle, the block SHALL commit writes using the latched values, then return to IDLE. Back-to-back setup in the following cycle SHALL be accepted.
REQ-021 In ACCESS with Psel=0 or Penable=0 (abort), the block SHALL set STATUS[0], return to IDLE, and perform no write.
REQ-022 In ACCESS, if Paddr, Pwrite or Pwdata differs from the latched value, the block SHALL set STATUS[0]. The transfer SHALL complete using the latched values.
REQ-023 Pslverr SHALL be 1 with Pready in any of these cases: latched Paddr[1:0]!=0; Paddr[31:6]!=BASE_ADDR[31:6]; a write to ID. Errored writes SHALL modify nothing.
REQ-024 Prdata SHALL equal the addressed word when Pready=1 and the read is error-free, and 0 otherwise.
REQ-025 A write to STATUS SHALL clear each bit written as 1 (W1C). If a clear and a set occur in the same cycle, the set SHALL win.
REQ-026 STATUS[4:1] SHALL hold the saturating count of Pslverr responses; it SHALL be cleared by writing 1 to STATUS[1].

Reset
REQ-027 Hresetn low SHALL asynchronously force: state IDLE, wcnt 0, registers 0x0-0xE to 0, Pready 0, Pslverr 0, Prdata 0.
REQ-028 Reset asserted during ACCESS SHALL abort the transfer with no write and SHALL NOT set STATUS[0].

Structure
REQ-029 Package apb_pkg SHALL hold the state encoding, the ID constant, the register offsets (STATUS=4'hE, ID=4'hF) and STATUS bit positions.
REQ-030 Sub-module apb_regbank (16x32 storage, W1C STATUS, read mux) SHALL be instantiated. The FSM, wait counter and error decode SHALL stay in the top level.

Verification
REQ-031 With WAIT_STATES=0: write 0xDEADBEEF to 0x8000_0008, then read 0x8000_0008 -> Pready in the 2nd cycle of each transfer, Prdata=0xDEADBEEF, Pslverr=0.
REQ-032 With WAIT_STATES=3: read 0x8000_003C -> Pready low for 3 access cycles then high, Prdata=0xA9B0_0001.
REQ-033 Write to 0x8000_003C, 0x8000_0042 and 0x9000_0000 -> Pslverr=1 on each, ID unchanged, STATUS[4:1]=3; write 0x2 to 0x8000_0038 -> STATUS[4:1]=0.
REQ-034 Drop Psel mid-ACCESS during a write of 0x1234 to reg 0x1 -> no Pready, reg 0x1 unchanged, STATUS[0]=1; write 0x1 to STATUS -> STATUS[0]=0.
REQ-035 Assert Hresetn low mid-write -> outputs 0 immediately; after release, reads of 0x0-0xE return 0 and STATUS=0.
